// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage RV32I core: shadows the EX/MEM/WB destination info,
// drives operand forwarding, load-use stalls with bubble insertion, and redirect flushes.
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              pc_sel_memwb,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t                ex_q, mem_q, wb_q;
  slot_t                ex_d, mem_d;
  state_t               state_q;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                 hazard_s;
  logic                 flush_s;
  logic                 stall_s;
  logic [1:0]           fwd_a_s, fwd_b_s;

  // A producer slot can feed an EX operand only if it really writes a non-x0 register.
  function automatic logic writes_reg(input slot_t s, input logic [REG_AW-1:0] rs);
    writes_reg = s.valid & s.reg_write & (s.rd != REG_ZERO) & (s.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                         input logic [REG_AW-1:0] rs);
    if (!ex.valid) begin
      fwd_sel = 2'b00;
    end else if (writes_reg(mem, rs)) begin
      fwd_sel = 2'b01;
    end else if (writes_reg(wb, rs)) begin
      fwd_sel = 2'b10;
    end else begin
      fwd_sel = 2'b00;
    end
  endfunction

  // Hazard, flush and forwarding decode; outputs are held low while reset is asserted.
  always_comb begin
    hazard_s = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != REG_ZERO) &
               ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    flush_s  = reset_n & pc_sel_memwb & (state_q != ST_REDIRECT);
    stall_s  = reset_n & hazard_s & ~flush_s & (state_q != ST_STALL);
    if (reset_n) begin
      fwd_a_s = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs1);
      fwd_b_s = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs2);
    end else begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end
  end

  // Next contents of the EX/MEM slots and the saturating event counters.
  always_comb begin
    ex_d        = {$bits(slot_t){1'b0}};
    mem_d       = ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_valid && !stall_s && !flush_s) begin
      ex_d.valid     = 1'b1;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end else begin
      ex_d = {$bits(slot_t){1'b0}};
    end
    if (flush_s) begin
      mem_d = {$bits(slot_t){1'b0}};
    end else begin
      mem_d = ex_q;
    end
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Shadow pipeline, steering FSM and counters; REDIRECT ignores pc_sel since that branch left WB.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q        <= {$bits(slot_t){1'b0}};
      mem_q       <= {$bits(slot_t){1'b0}};
      wb_q        <= {$bits(slot_t){1'b0}};
      state_q     <= ST_RUN;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      case (state_q)
        ST_RUN: begin
          if (pc_sel_memwb) begin
            state_q <= ST_REDIRECT;
          end else if (stall_s) begin
            state_q <= ST_STALL;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_STALL: begin
          if (pc_sel_memwb) begin
            state_q <= ST_REDIRECT;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_REDIRECT: state_q <= ST_RUN;
        default:     state_q <= ST_RUN;
      endcase
    end
  end

  assign stall_if    = stall_s;
  assign stall_id    = stall_s;
  assign bubble_idex = stall_s;
  assign flush_ifid  = flush_s;
  assign flush_idex  = flush_s;
  assign flush_exmem = flush_s;
  assign fwd_a       = fwd_a_s;
  assign fwd_b       = fwd_b_s;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
